// File: rtl/bit_shift_pkg.sv
// Shared widths, direction encoding and payload types for the widening shifter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bit_shift_pkg;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 3;
  localparam int CNT_W   = 16;

  // Same encoding as the companion narrowing shifter.
  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

  typedef struct packed {
    logic [SHIFT_W-1:0] amount;
    logic               direction;
  } shift_cfg_t;

  // Stage 1 holds the raw sample plus the config it was accepted under,
  // so later config writes never touch beats already in flight.
  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            last;
    shift_cfg_t      cfg;
  } s1_payload_t;

  typedef struct packed {
    logic [OUT_W-1:0] result;
    logic             last;
  } s2_payload_t;

  // Sign-extend then shift. OUT_W >= IN_W + 2**SHIFT_W - 1 keeps the left
  // shift free of overflow; the right shift is arithmetic with no rounding.
  function automatic logic [OUT_W-1:0] expand_shift(input logic [IN_W-1:0] din,
                                                    input shift_cfg_t      cfg);
    logic signed [OUT_W-1:0] sext;
    logic        [OUT_W-1:0] res;
    sext = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
    if (cfg.direction == SHIFT_LEFT) begin
      res = sext << cfg.amount;
    end else begin
      res = sext >>> cfg.amount;
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_expand_if.sv
// Config, input-stream and output-stream bundle of the widening shifter.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs; master = stream producer/consumer side.
interface bit_expand_if;
  import bit_shift_pkg::*;

  logic               cfg_valid;
  logic [SHIFT_W-1:0] cfg_shift_amount;
  logic               cfg_shift_direction;

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;

  logic [CNT_W-1:0]   beat_count;

  modport master (
    output cfg_valid, cfg_shift_amount, cfg_shift_direction,
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, beat_count
  );

  modport slave (
    input  cfg_valid, cfg_shift_amount, cfg_shift_direction,
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, beat_count
  );

endinterface

// File: rtl/expand_stage.sv
// Generic one-entry valid/ready register slice for an arbitrary payload type T.
// Latency: 1 cycle. Ports: i_vld/o_rdy/i_dat upstream, o_vld/i_rdy/o_dat downstream.
// Backpressure: o_rdy = !full || i_rdy, so a full slice still accepts on the cycle it drains.
module expand_stage #(
  parameter type T = logic
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vld,
  output logic o_rdy,
  input  T     i_dat,
  output logic o_vld,
  input  logic i_rdy,
  output T     o_dat
);

  logic r_vld;
  T     r_dat;

  assign o_rdy = !r_vld || i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  // Payload only moves when a real beat arrives, so a held output stays
  // stable and an emptied slice keeps its last value harmlessly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_dat <= i_dat;
      end
    end
  end

endmodule

// File: rtl/bit_expand.sv
// Streaming int8 -> int16 widening shifter (sign-extend, then left or arithmetic-right shift).
// Latency: 2 register stages (S1 capture, S2 result); 1 beat/cycle sustained, 2 beats of storage.
// Backpressure: in_ready = !S1_valid || S2_can_load, from registered state and out_ready only.
module bit_expand
  import bit_shift_pkg::*;
(
  input logic         clock,
  input logic         reset_n,
  bit_expand_if.slave bus
);

  shift_cfg_t       r_cfg;
  logic [CNT_W-1:0] r_beat_count;

  s1_payload_t w_s1_in;
  s1_payload_t w_s1_dat;
  s2_payload_t w_s2_in;
  s2_payload_t w_s2_dat;
  logic        w_s1_vld;
  logic        w_s2_rdy;
  logic        w_out_xfer;

  // A beat accepted alongside a config write snapshots the old r_cfg,
  // because the write only lands at that same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg.amount    <= '0;
      r_cfg.direction <= SHIFT_LEFT;
    end else if (bus.cfg_valid) begin
      r_cfg.amount    <= bus.cfg_shift_amount;
      r_cfg.direction <= bus.cfg_shift_direction;
    end
  end

  assign w_s1_in.data = bus.in_data;
  assign w_s1_in.last = bus.in_last;
  assign w_s1_in.cfg  = r_cfg;

  expand_stage #(.T(s1_payload_t)) u_s1 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_vld   (bus.in_valid),
    .o_rdy   (bus.in_ready),
    .i_dat   (w_s1_in),
    .o_vld   (w_s1_vld),
    .i_rdy   (w_s2_rdy),
    .o_dat   (w_s1_dat)
  );

  assign w_s2_in.result = expand_shift(w_s1_dat.data, w_s1_dat.cfg);
  assign w_s2_in.last   = w_s1_dat.last;

  expand_stage #(.T(s2_payload_t)) u_s2 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_vld   (w_s1_vld),
    .o_rdy   (w_s2_rdy),
    .i_dat   (w_s2_in),
    .o_vld   (bus.out_valid),
    .i_rdy   (bus.out_ready),
    .o_dat   (w_s2_dat)
  );

  assign bus.out_data = w_s2_dat.result;
  assign bus.out_last = w_s2_dat.last;

  assign w_out_xfer = bus.out_valid && bus.out_ready;

  // Counts output handshakes within a tile; the last beat's handshake
  // clears it so the next tile starts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_count <= '0;
    end else if (w_out_xfer) begin
      if (bus.out_last) begin
        r_beat_count <= '0;
      end else begin
        r_beat_count <= r_beat_count + CNT_W'(1);
      end
    end
  end

  assign bus.beat_count = r_beat_count;

  // A stalled output beat must not change under the consumer.
  property p_out_hold;
    @(posedge clock) disable iff (!reset_n)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last));
  endproperty
  a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_bit_expand.sv
module tb_bit_expand;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  bit_expand_if bus ();

  bit_expand dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic set_cfg(input logic [2:0] amt, input logic dir);
    bus.cfg_valid = 1'b1;
    bus.cfg_shift_amount = amt;
    bus.cfg_shift_direction = dir;
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
  endtask

  // Holds the beat until accepted (bounded); returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = bus.in_ready;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // With out_ready high: waits (bounded) for out_valid, captures, consumes.
  // On timeout d/l are X so any comparison on them fails.
  task automatic wait_out(output logic [15:0] d, output logic l, output int cyc);
    d = 'x; l = 'x; cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (bus.out_valid) begin
      d = bus.out_data;
      l = bus.out_last;
      @(posedge clock); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_shift_amount = '0; bus.cfg_shift_direction = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #12;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    n_tests++; if (bus.beat_count !== 16'd0) begin n_fail++; $display("FAIL reset_beat_count: got %0d expected 0", bus.beat_count); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_left_shift();
    logic [15:0] d; logic l; int cyc;
    do_reset();
    set_cfg(3'd3, 1'b1);
    send_beat(8'hAA, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'hFD50) begin n_fail++; $display("FAIL left3_AA: got %h expected fd50", d); end
    // Accepted at edge N, visible after edge N+1 (two register stages).
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL left_latency: got %0d extra edges expected 1", cyc); end
    set_cfg(3'd7, 1'b1);
    send_beat(8'h80, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'hC000) begin n_fail++; $display("FAIL left7_80: got %h expected c000", d); end
  endtask

  task automatic test_right_shift();
    logic [15:0] d; logic l; int cyc;
    do_reset();
    set_cfg(3'd2, 1'b0);
    send_beat(8'h55, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'h0015) begin n_fail++; $display("FAIL right2_55: got %h expected 0015", d); end
    set_cfg(3'd7, 1'b0);
    send_beat(8'h80, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL right7_80: got %h expected ffff", d); end
    send_beat(8'h7F, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL right7_7F: got %h expected 0000", d); end
  endtask

  task automatic test_cfg_race();
    logic [15:0] d; logic l; int cyc;
    do_reset();
    set_cfg(3'd3, 1'b1);
    // Config write and beat accept share an edge: beat must use left-3.
    bus.cfg_valid = 1'b1; bus.cfg_shift_amount = 3'd1; bus.cfg_shift_direction = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h10; bus.in_last = 1'b0;
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'h0080) begin n_fail++; $display("FAIL race_old_cfg: got %h expected 0080", d); end
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'h0008) begin n_fail++; $display("FAIL race_new_cfg: got %h expected 0008", d); end
  endtask

  task automatic test_backpressure();
    int next_in; int got; int gaps; bit acc;
    do_reset();
    bus.out_ready = 1'b0;
    next_in = 1;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (next_in <= 6);
      bus.in_data  = 8'(next_in);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (acc) next_in++;
      if (bus.out_valid) begin
        n_tests++; if (bus.out_data !== 16'h0001) begin n_fail++; $display("FAIL stall_hold_c%0d: got %h expected 0001", c, bus.out_data); end
      end
    end
    n_tests++; if (next_in - 1 !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 2", next_in - 1); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    #1;
    got = 0; gaps = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (bus.out_valid) begin
        n_tests++; if (bus.out_data !== 16'(got + 1)) begin n_fail++; $display("FAIL flow_order_%0d: got %h expected %h", got, bus.out_data, 16'(got + 1)); end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      bus.in_valid = (next_in <= 6);
      bus.in_data  = 8'(next_in);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (acc) next_in++;
    end
    bus.in_valid = 1'b0;
    n_tests++; if (got !== 6) begin n_fail++; $display("FAIL flow_count: got %0d expected 6", got); end
    n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL flow_gaps: got %0d expected 0", gaps); end
  endtask

  task automatic test_tile_counter();
    int sent; int got; bit prev_xfer; bit acc;
    do_reset();
    sent = 0; got = 0; prev_xfer = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (prev_xfer) begin
        n_tests++;
        if (bus.beat_count !== 16'((got == 4) ? 0 : got)) begin
          n_fail++; $display("FAIL tile_count_%0d: got %0d expected %0d", got, bus.beat_count, (got == 4) ? 0 : got);
        end
      end
      if (got == 4) break;
      prev_xfer = 1'b0;
      if (bus.out_valid) begin
        n_tests++; if (bus.out_data !== 16'(got + 1)) begin n_fail++; $display("FAIL tile_data_%0d: got %h expected %h", got, bus.out_data, 16'(got + 1)); end
        n_tests++; if (bus.out_last !== (got == 3)) begin n_fail++; $display("FAIL tile_last_%0d: got %b expected %b", got, bus.out_last, (got == 3)); end
        got++;
        prev_xfer = 1'b1;
      end
      bus.in_valid = (sent < 4);
      bus.in_data  = 8'(sent + 1);
      bus.in_last  = (sent == 3);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL tile_beats: got %0d expected 4", got); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] d; logic l; int cyc;
    do_reset();
    set_cfg(3'd5, 1'b0);
    send_beat(8'h20, 1'b0);
    wait_out(d, l, cyc);
    send_beat(8'h20, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (bus.beat_count !== 16'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", bus.beat_count); end
    bus.out_ready = 1'b0;
    send_beat(8'h40, 1'b0);
    send_beat(8'h41, 1'b0);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got in_ready %b expected 0", bus.in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_out_data: got %h expected 0000", bus.out_data); end
    n_tests++; if (bus.beat_count !== 16'd0) begin n_fail++; $display("FAIL mid_beat_count: got %0d expected 0", bus.beat_count); end
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    send_beat(8'h03, 1'b0);
    wait_out(d, l, cyc);
    n_tests++; if (d !== 16'h0003) begin n_fail++; $display("FAIL mid_default_cfg: got %h expected 0003", d); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_left_shift();
    test_right_shift();
    test_cfg_race();
    test_backpressure();
    test_tile_counter();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
